// File: rtl/dmr_retry_compare.sv
// DMR join/compare stage: pairs the two redundant lane streams, compares payload
// and ID, and marks mismatching or timed-out items so the retry logic replays them.

module dmr_retry_compare_checker #(
    parameter int unsigned DW  = 8,
    parameter int unsigned IDW = 2
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           valid_o,
    input  logic           ready_i,
    input  logic [DW-1:0]  data_o,
    input  logic [IDW-1:0] id_o,
    input  logic           needs_retry_o,
    input  logic [1:0]     held,
    input  logic [1:0]     discard
);

    // An offered output item must not change until it is accepted
    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_o && !ready_i) |=> (valid_o && $stable(data_o) && $stable(id_o)
                                   && $stable(needs_retry_o)));

    // A lane waiting to swallow a late copy never holds an item at the same time
    a_discard_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((discard & held) == 2'b00));

endmodule

module dmr_retry_compare #(
    parameter type         DataType = logic [7:0],
    parameter int unsigned IDSize   = 2,
    parameter int unsigned MaxSkew  = 8,
    parameter int unsigned CntWidth = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [1:0][$bits(DataType)-1:0] data_i,
    input  logic [1:0][IDSize-1:0]          id_i,
    input  logic [1:0]                      valid_i,
    output logic [1:0]                      ready_o,
    output logic [$bits(DataType)-1:0]      data_o,
    output logic [IDSize-1:0]               id_o,
    output logic                            needs_retry_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [CntWidth-1:0]             fault_cnt_o
);

    localparam int unsigned DW    = $bits(DataType);
    localparam int unsigned SkewW = 8;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_HELD  = 1'b1
    } lane_state_e;

    function automatic logic lanes_differ(
        input logic [DW-1:0]     d0,
        input logic [DW-1:0]     d1,
        input logic [IDSize-1:0] i0,
        input logic [IDSize-1:0] i1
    );
        return (d0 != d1) || (i0 != i1);
    endfunction

    lane_state_e       lane_state_r     [2];
    lane_state_e       lane_state_nxt_s [2];
    logic [DW-1:0]     buf_data_r       [2];
    logic [IDSize-1:0] buf_id_r         [2];
    logic [1:0]        discard_r;
    logic [1:0]        discard_nxt_s;
    logic [SkewW-1:0]  skew_cnt_r;
    logic [SkewW-1:0]  skew_cnt_nxt_s;

    logic [1:0]        held_s;
    logic [1:0]        ready_s;
    logic [1:0]        hs_s;
    logic [1:0]        store_s;
    logic [1:0]        tmo_drop_s;
    logic [1:0]        tmo_miss_s;
    logic              can_load_s;
    logic              one_held_s;
    logic              at_max_s;
    logic              pair_s;
    logic              timeout_s;
    logic              miss_lane_s;
    logic              held_lane_s;
    logic              load_s;
    logic              load_retry_s;
    logic [DW-1:0]     load_data_s;
    logic [IDSize-1:0] load_id_s;

    // Lane state register, skew counter and discard flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 2; k++) begin
                lane_state_r[k] <= LANE_EMPTY;
            end
            discard_r  <= 2'b00;
            skew_cnt_r <= {SkewW{1'b0}};
        end else begin
            for (int k = 0; k < 2; k++) begin
                lane_state_r[k] <= lane_state_nxt_s[k];
            end
            discard_r  <= discard_nxt_s;
            skew_cnt_r <= skew_cnt_nxt_s;
        end
    end

    // Decode lane status into pair/timeout decisions and lane handshakes
    always_comb begin
        held_s      = {lane_state_r[1] == LANE_HELD, lane_state_r[0] == LANE_HELD};
        can_load_s  = ~valid_o | ready_i;
        one_held_s  = held_s[0] ^ held_s[1];
        at_max_s    = (skew_cnt_r == SkewW'(MaxSkew));
        pair_s      = held_s[0] & held_s[1] & can_load_s;
        timeout_s   = at_max_s & one_held_s & can_load_s;
        // With exactly one lane held, the missing lane is the other one
        miss_lane_s = held_s[0];
        held_lane_s = ~held_s[0];
        tmo_drop_s  = {timeout_s & ~miss_lane_s, timeout_s & miss_lane_s};
        tmo_miss_s  = {timeout_s & miss_lane_s, timeout_s & ~miss_lane_s};
        ready_s     = ~held_s & ~tmo_miss_s;
        hs_s        = valid_i & ready_s;
        store_s     = hs_s & ~discard_r;
    end

    assign ready_o = ready_s;

    // Next lane state, discard flags, skew count and output-load selection
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            case (lane_state_r[k])
                LANE_EMPTY: begin
                    if (store_s[k]) begin
                        lane_state_nxt_s[k] = LANE_HELD;
                    end else begin
                        lane_state_nxt_s[k] = LANE_EMPTY;
                    end
                end
                LANE_HELD: begin
                    if (pair_s || tmo_drop_s[k]) begin
                        lane_state_nxt_s[k] = LANE_EMPTY;
                    end else begin
                        lane_state_nxt_s[k] = LANE_HELD;
                    end
                end
                default: lane_state_nxt_s[k] = LANE_EMPTY;
            endcase
        end

        discard_nxt_s = (discard_r & ~hs_s) | tmo_miss_s;

        if (timeout_s) begin
            skew_cnt_nxt_s = {SkewW{1'b0}};
        end else if (one_held_s) begin
            // Park at the limit while the output is blocked
            if (at_max_s) begin
                skew_cnt_nxt_s = skew_cnt_r;
            end else begin
                skew_cnt_nxt_s = skew_cnt_r + 8'd1;
            end
        end else begin
            skew_cnt_nxt_s = {SkewW{1'b0}};
        end

        load_s = pair_s | timeout_s;
        if (pair_s) begin
            load_data_s  = buf_data_r[0];
            load_id_s    = buf_id_r[0];
            load_retry_s = lanes_differ(buf_data_r[0], buf_data_r[1], buf_id_r[0], buf_id_r[1]);
        end else begin
            load_data_s  = buf_data_r[held_lane_s];
            load_id_s    = buf_id_r[held_lane_s];
            load_retry_s = 1'b1;
        end
    end

    // Lane buffer payload capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 2; k++) begin
                buf_data_r[k] <= {DW{1'b0}};
                buf_id_r[k]   <= {IDSize{1'b0}};
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (store_s[k]) begin
                    buf_data_r[k] <= data_i[k];
                    buf_id_r[k]   <= id_i[k];
                end
            end
        end
    end

    // Output register and saturating fault counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o       <= 1'b0;
            data_o        <= {DW{1'b0}};
            id_o          <= {IDSize{1'b0}};
            needs_retry_o <= 1'b0;
            fault_cnt_o   <= {CntWidth{1'b0}};
        end else begin
            if (load_s) begin
                valid_o       <= 1'b1;
                data_o        <= load_data_s;
                id_o          <= load_id_s;
                needs_retry_o <= load_retry_s;
                if (load_retry_s && !(&fault_cnt_o)) begin
                    fault_cnt_o <= fault_cnt_o + CntWidth'(1);
                end
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    dmr_retry_compare_checker #(
        .DW  (DW),
        .IDW (IDSize)
    ) u_checker (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .data_o        (data_o),
        .id_o          (id_o),
        .needs_retry_o (needs_retry_o),
        .held          (held_s),
        .discard       (discard_r)
    );

endmodule

// File: tb/tb_dmr_retry_compare.sv
// Directed bench for dmr_retry_compare: scoreboard of expected output items,
// popped by an independent monitor whenever an output item is accepted.

module tb_dmr_retry_compare;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0][7:0] data_in;
    logic [1:0][1:0] id_in;
    logic [1:0]      valid_in;
    logic            ready_in;

    logic [1:0]  ready_a, ready_b;
    logic [7:0]  data_a, data_b;
    logic [1:0]  id_a, id_b;
    logic        retry_a, retry_b, valid_a, valid_b;
    logic [15:0] fault_a;
    logic [1:0]  fault_b;

    typedef struct {
        logic [7:0] d;
        logic [1:0] id;
        logic       r;
        int         f;
    } exp_t;

    exp_t sb[$];
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   exp_faults = 0;

    always #5 clk = ~clk;

    dmr_retry_compare dut_a (
        .clk_i (clk), .rst_ni (rst_n), .data_i (data_in), .id_i (id_in),
        .valid_i (valid_in), .ready_o (ready_a), .data_o (data_a), .id_o (id_a),
        .needs_retry_o (retry_a), .valid_o (valid_a), .ready_i (ready_in),
        .fault_cnt_o (fault_a)
    );

    dmr_retry_compare #(.CntWidth(2)) dut_b (
        .clk_i (clk), .rst_ni (rst_n), .data_i (data_in), .id_i (id_in),
        .valid_i (valid_in), .ready_o (ready_b), .data_o (data_b), .id_o (id_b),
        .needs_retry_o (retry_b), .valid_o (valid_b), .ready_i (ready_in),
        .fault_cnt_o (fault_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] id, input logic r);
        exp_t e;
        if (r) exp_faults++;
        e.d  = d;
        e.id = id;
        e.r  = r;
        e.f  = exp_faults;
        sb.push_back(e);
    endtask

    // Offer one item on lane k after dly cycles; returns just after the accepting edge
    task automatic lane_send(input int k, input logic [7:0] d, input logic [1:0] id, input int dly);
        bit done = 1'b0;
        repeat (dly) @(posedge clk);
        #1;
        valid_in[k] = 1'b1;
        data_in[k]  = d;
        id_in[k]    = id;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (ready_a[k]) done = 1'b1;
            @(posedge clk);
        end
        #1;
        valid_in[k] = 1'b0;
        if (!done) check($sformatf("lane%0d_handshake_timeout", k), 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every accepted output item against the scoreboard head
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && valid_a && ready_in) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got data %0h id %0h retry %0b, required no item",
                             data_a, id_a, retry_a);
                end else begin
                    e = sb.pop_front();
                    check("out_data", data_a, e.d);
                    check("out_id", id_a, e.id);
                    check("out_retry", retry_a, e.r);
                    check("out_fault_cnt", fault_a, e.f);
                    check("b_valid", valid_b, 1);
                    check("b_data", data_b, e.d);
                    check("b_retry", retry_b, e.r);
                    check("b_fault_cnt_sat", fault_b, (e.f > 3) ? 3 : e.f);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
        $fatal(1, "bench did not finish");
    end

    initial begin : stimulus
        logic [7:0] dv;
        rst_n    = 1'b0;
        valid_in = 2'b00;
        data_in  = '0;
        id_in    = '0;
        ready_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", valid_a, 0);
        check("rst_data", data_a, 0);
        check("rst_id", id_a, 0);
        check("rst_retry", retry_a, 0);
        check("rst_fault", fault_a, 0);
        check("rst_ready", ready_a, 2'b11);
        check("rst_ready_b", ready_b, 2'b11);
        idle(1);

        // Aligned matching pair, two-cycle latency
        push(8'hA5, 2'd2, 1'b0);
        fork
            lane_send(0, 8'hA5, 2'd2, 0);
            lane_send(1, 8'hA5, 2'd2, 0);
        join
        @(negedge clk);
        check("lat_cycle1_valid", valid_a, 0);
        @(negedge clk);
        check("lat_cycle2_valid", valid_a, 1);
        idle(2);

        // Data mismatch, then ID mismatch
        push(8'h3C, 2'd1, 1'b1);
        fork
            lane_send(0, 8'h3C, 2'd1, 0);
            lane_send(1, 8'h3D, 2'd1, 0);
        join
        push(8'h77, 2'd1, 1'b1);
        fork
            lane_send(0, 8'h77, 2'd1, 0);
            lane_send(1, 8'h77, 2'd2, 0);
        join
        idle(4);

        // Lane 1 five cycles late, within the skew window
        push(8'h5A, 2'd0, 1'b0);
        fork
            lane_send(0, 8'h5A, 2'd0, 0);
            lane_send(1, 8'h5A, 2'd0, 5);
            begin
                repeat (3) @(negedge clk);
                check("skew_ready0_low", ready_a[0], 0);
            end
        join
        idle(4);

        // Lane 1 silent: timeout after MaxSkew cycles, late copy swallowed
        push(8'h11, 2'd1, 1'b1);
        lane_send(0, 8'h11, 2'd1, 0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 8) check("tmo_ready_before", ready_a, 2'b10);
            if (i == 9) check("tmo_ready_at_timeout", ready_a, 2'b00);
        end
        idle(3);
        lane_send(1, 8'h11, 2'd1, 0);
        idle(2);
        push(8'h22, 2'd0, 1'b0);
        fork
            lane_send(0, 8'h22, 2'd0, 0);
            lane_send(1, 8'h22, 2'd0, 0);
        join
        idle(4);

        // Backpressure: output holds, each lane takes one more item then stalls
        ready_in = 1'b0;
        push(8'h44, 2'd3, 1'b0);
        push(8'h55, 2'd0, 1'b0);
        fork
            lane_send(0, 8'h44, 2'd3, 0);
            lane_send(1, 8'h44, 2'd3, 0);
        join
        fork
            lane_send(0, 8'h55, 2'd0, 0);
            lane_send(1, 8'h55, 2'd0, 0);
        join
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", valid_a, 1);
            check("bp_data", data_a, 8'h44);
            check("bp_id", id_a, 2'd3);
            check("bp_ready", ready_a, 2'b00);
        end
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        idle(6);
        check("sb_drained_mid", sb.size(), 0);

        // Fresh start, then five mismatches saturate the 2-bit counter
        rst_n = 1'b0;
        exp_faults = 0;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            dv = 8'h60 + 8'(i);
            push(dv, 2'(i), 1'b1);
            fork
                lane_send(0, dv, 2'(i), 0);
                lane_send(1, dv ^ 8'h01, 2'(i), 0);
            join
        end
        idle(4);

        // Reset while a faulty item waits at the output
        ready_in = 1'b0;
        fork
            lane_send(0, 8'h99, 2'd1, 0);
            lane_send(1, 8'h98, 2'd1, 0);
        join
        repeat (2) @(negedge clk);
        check("pre_rst_valid", valid_a, 1);
        check("pre_rst_fault_a", fault_a, 6);
        check("pre_rst_fault_b", fault_b, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", valid_a, 0);
        check("async_rst_fault_a", fault_a, 0);
        check("async_rst_fault_b", fault_b, 0);
        check("async_rst_ready", ready_a, 2'b11);
        ready_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        check("sb_drained_end", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmr_retry_compare.md
Name: dmr_retry_compare

Overview:
- Producer of the `needs_retry` flag consumed by `retry_end`. Sits between two redundant (DMR) copies of a datapath and the `retry_end` upstream port.
- Joins the two lane streams, including lanes that are skewed in time. Compares data and ID.
- Emits one stream of data, ID and `needs_retry_o`. A mismatch or a lane timeout raises `needs_retry_o` so `retry_start` replays the item.

Parameters:
- `DataType`, `logic [7:0]`, payload type compared between lanes.
- `IDSize`, 2, width of the retry ID.
- `MaxSkew`, 8, max cycles one lane may wait for the other before timeout; legal range 1..255.
- `CntWidth`, 16, width of the saturating fault counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous reset, active-low.
- `data_i`  in  2 x $bits(DataType)  lane payloads, index 0/1.
- `id_i`  in  2 x IDSize  lane retry IDs.
- `valid_i`  in  2  per-lane valid.
- `ready_o`  out  2  per-lane ready.
- `data_o`  out  $bits(DataType)  joined payload, taken from lane 0.
- `id_o`  out  IDSize  joined ID, taken from lane 0.
- `needs_retry_o`  out  1  item faulty; downstream must request a replay.
- `valid_o`  out  1  output valid.
- `ready_i`  in  1  output ready.
- `fault_cnt_o`  out  CntWidth  number of items emitted with `needs_retry_o` = 1, saturating.

Behaviour:
- Reset (async): all state clears.
  - `valid_o`, `data_o`, `id_o`, `needs_retry_o` and `fault_cnt_o` all go to 0.
  - Both lane buffers empty; skew counter 0; discard flags 0.
  - `ready_o` is 2'b11 from the first cycle after reset.
- Reset mid-operation drops all buffered and output items without any handshake.
- Per-lane buffer: one entry with states EMPTY and HELD.
  - `ready_o[k]` = buffer EMPTY, and lane k is not being timed out this cycle.
  - A lane handshake (`valid_i[k]` & `ready_o[k]`) loads the buffer with data and ID, unless `discard[k]` is set.
  - If `discard[k]` is set, the handshake is consumed, `discard[k]` clears and nothing is stored.
- Output register: one entry. It can load when `!valid_o | ready_i`; this allows a load in the same cycle as a pop.
- Pair: both buffers HELD and output can load.
  - Output register gets lane-0 data and ID.
  - `needs_retry_o` = (data0 != data1) | (id0 != id1).
  - Both buffers go to EMPTY.
- Latency: the later lane's handshake in cycle N gives `valid_o` in cycle N+2 when there is no backpressure. Throughput is one item per 2 cycles per lane.
- Skew counter:
  - Cycles when exactly one buffer is HELD: counter increments.
  - Otherwise: counter resets to 0.
- Timeout: counter == MaxSkew, exactly one buffer HELD, and output can load.
  - Output register gets the held lane's data and ID, with `needs_retry_o` = 1.
  - The held buffer goes to EMPTY and the counter goes to 0.
  - `discard` of the missing lane is set. That lane's late copy is later swallowed.
  - In the timeout cycle, `ready_o` of the missing lane is forced to 0, so an arrival in that same cycle is not lost or double-counted.
- If the output cannot load at timeout, the counter holds at MaxSkew and the pair/timeout decision is retried each cycle. A pair formed in the meantime takes priority over timeout.
- `discard[k]` set while lane k's buffer is HELD is not reachable. The timeout only targets the empty lane.
- Output held stable while `valid_o` & !`ready_i` (AXI-style). `needs_retry_o` is meaningful only when `valid_o` = 1.
- `fault_cnt_o` increments by 1 on each output-register load with `needs_retry_o` = 1. It saturates at all ones.
- Lane 1 data and ID are never forwarded except on a lane-1 timeout.

Test Plan:
- Both lanes present 8'hA5 / id 2 in the same cycle, `ready_i` = 1 -> `valid_o` 2 cycles later with data 8'hA5, id 2, `needs_retry_o` 0; `fault_cnt_o` stays 0.
- Lane 0 sends 8'h3C, lane 1 sends 8'h3D, same id 1 -> `needs_retry_o` 1, data 8'h3C, `fault_cnt_o` = 1. Repeat with equal data but ids 1 vs 2 -> `needs_retry_o` 1, `fault_cnt_o` = 2.
- Lane 1 arrives 5 cycles after lane 0 (MaxSkew = 8), values equal -> one output with `needs_retry_o` 0; `ready_o[0]` low during the wait.
- Lane 1 silent for 8 cycles after lane 0 holds 8'h11 -> output 8'h11 with `needs_retry_o` 1. Lane 1's later 8'h11 is consumed with no output. The next matched pair 8'h22 is emitted with `needs_retry_o` 0.
- `ready_i` held 0 for 10 cycles during a pending pair -> `valid_o`, `data_o` and `id_o` stay constant. Each lane takes at most one further item (buffers HELD) until `ready_i` = 1.
- CntWidth = 2, 5 consecutive mismatches -> `fault_cnt_o` reads 1, 2, 3, 3, 3. Assert `rst_ni` mid-stream -> `valid_o` 0 and counter 0 immediately.
